// File: rtl/light_sequencer.sv
// Multi-phase lamp sequencer: WHITE -> SUN -> YELLOW, each phase counting its
// BCD duration down to zero at a run or demo tick rate, with run/pause on a key.
module light_sequencer #(
  parameter int                  TICK_DIV = 5000000,
  parameter int                  DEMO_DIV = 10,
  parameter int                  DIGITS   = 2,
  parameter logic [4*DIGITS-1:0] DUR_W    = 8'h30,
  parameter logic [4*DIGITS-1:0] DUR_S    = 8'h20,
  parameter logic [4*DIGITS-1:0] DUR_Y    = 8'h05
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  key,
  input  logic                  demo,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [3:0]            led,
  output logic [1:0]            phase,
  output logic                  running,
  output logic                  phase_done
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(TICK_DIV + 1);
  localparam logic [CW-1:0] LIM_RUN  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] LIM_DEMO = CW'(TICK_DIV / DEMO_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  typedef enum logic [1:0] {WHITE = 2'd0, SUN = 2'd1, YELLOW = 2'd2} phase_t;

  state_t        state;
  phase_t        phase_r;
  logic [CW-1:0] cnt;
  logic          key_q;
  logic          press;
  logic          tick;
  logic [CW-1:0] lim;

  assign press = key & ~key_q;
  assign lim   = demo ? LIM_DEMO : LIM_RUN;
  // >= rather than == so that a switch to the shorter demo period mid-count
  // wraps immediately instead of running past the limit.
  assign tick  = (cnt >= lim);
  assign phase = phase_r;

  function automatic logic [BW-1:0] bcd_dec(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      WHITE:   return SUN;
      SUN:     return YELLOW;
      default: return WHITE;
    endcase
  endfunction

  function automatic logic [BW-1:0] dur_of(input phase_t p);
    case (p)
      SUN:     return DUR_S;
      YELLOW:  return DUR_Y;
      default: return DUR_W;
    endcase
  endfunction

  function automatic logic [3:0] led_of(input phase_t p);
    case (p)
      SUN:     return 4'b0110;
      YELLOW:  return 4'b0011;
      default: return 4'b1100;
    endcase
  endfunction

  // Power switch beats the key, the key beats the tick; a press in RUN
  // therefore swallows a coincident tick and leaves the counter where it was.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      phase_r    <= WHITE;
      bcd        <= DUR_W;
      cnt        <= '0;
      key_q      <= 1'b1;
      led        <= 4'b0000;
      running    <= 1'b0;
      phase_done <= 1'b0;
    end else begin
      key_q      <= key;
      phase_done <= 1'b0;
      if (!en) begin
        state   <= IDLE;
        phase_r <= WHITE;
        bcd     <= DUR_W;
        cnt     <= '0;
        led     <= 4'b0000;
        running <= 1'b0;
      end else if (press) begin
        case (state)
          IDLE: begin
            state   <= RUN;
            cnt     <= '0;
            led     <= led_of(phase_r);
            running <= 1'b1;
          end
          RUN: begin
            state   <= PAUSE;
            led     <= 4'b0000;
            running <= 1'b0;
          end
          default: begin
            state   <= RUN;
            led     <= led_of(phase_r);
            running <= 1'b1;
          end
        endcase
      end else if (state == RUN) begin
        if (tick) begin
          cnt <= '0;
          if (bcd != '0) begin
            bcd <= bcd_dec(bcd);
          end else begin
            phase_r    <= next_phase(phase_r);
            bcd        <= dur_of(next_phase(phase_r));
            led        <= led_of(next_phase(phase_r));
            phase_done <= 1'b1;
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_light_sequencer.sv
// Directed bench for light_sequencer: phase sequencing, pause/resume, demo rate,
// BCD borrow, power switch and key-held-through-reset behaviour.
module tb_light_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       key = 1'b0;
  logic       demo = 1'b0;
  logic       key2 = 1'b0;
  logic       demo2 = 1'b1;
  logic [7:0] bcd, bcd2;
  logic [3:0] led, led2;
  logic [1:0] phase, phase2;
  logic       running, running2;
  logic       phase_done, phase_done2;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  light_sequencer #(
    .TICK_DIV(4), .DEMO_DIV(2), .DIGITS(2),
    .DUR_W(8'h03), .DUR_S(8'h02), .DUR_Y(8'h01)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .key(key), .demo(demo),
    .bcd(bcd), .led(led), .phase(phase), .running(running), .phase_done(phase_done)
  );

  // Second instance exercises the cross-digit borrow from 10 to 09.
  light_sequencer #(
    .TICK_DIV(4), .DEMO_DIV(2), .DIGITS(2),
    .DUR_W(8'h10), .DUR_S(8'h02), .DUR_Y(8'h01)
  ) dut2 (
    .clk(clk), .rst(rst), .en(en), .key(key2), .demo(demo2),
    .bcd(bcd2), .led(led2), .phase(phase2), .running(running2), .phase_done(phase_done2)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_press();
    key = 1'b1;
    @(negedge clk);
    key = 1'b0;
  endtask

  task automatic apply_press2();
    key2 = 1'b1;
    @(negedge clk);
    key2 = 1'b0;
  endtask

  initial begin
    wait_cycles(3);
    rst = 1'b1;
    check_output("rst_bcd", 32'(bcd), 32'h03);
    check_output("rst_phase", 32'(phase), 32'd0);
    check_output("rst_led", 32'(led), 32'h0);
    check_output("rst_running", 32'(running), 32'd0);
    check_output("rst_done", 32'(phase_done), 32'd0);
    check_output("rst_bcd2", 32'(bcd2), 32'h10);
    wait_cycles(1);

    apply_press();
    check_output("start_running", 32'(running), 32'd1);
    check_output("start_led", 32'(led), 32'hC);
    check_output("start_bcd", 32'(bcd), 32'h03);
    wait_cycles(3);
    check_output("pre_tick_bcd", 32'(bcd), 32'h03);
    wait_cycles(1);
    check_output("tick1_bcd", 32'(bcd), 32'h02);
    wait_cycles(4);
    check_output("tick2_bcd", 32'(bcd), 32'h01);
    wait_cycles(4);
    check_output("tick3_bcd", 32'(bcd), 32'h00);
    check_output("tick3_done", 32'(phase_done), 32'd0);
    wait_cycles(4);
    check_output("sun_phase", 32'(phase), 32'd1);
    check_output("sun_bcd", 32'(bcd), 32'h02);
    check_output("sun_led", 32'(led), 32'h6);
    check_output("sun_done", 32'(phase_done), 32'd1);
    wait_cycles(1);
    check_output("sun_done_clear", 32'(phase_done), 32'd0);
    wait_cycles(11);
    check_output("yel_phase", 32'(phase), 32'd2);
    check_output("yel_bcd", 32'(bcd), 32'h01);
    check_output("yel_led", 32'(led), 32'h3);
    check_output("yel_done", 32'(phase_done), 32'd1);
    wait_cycles(8);
    check_output("wrap_phase", 32'(phase), 32'd0);
    check_output("wrap_bcd", 32'(bcd), 32'h03);
    check_output("wrap_led", 32'(led), 32'hC);
    check_output("wrap_done", 32'(phase_done), 32'd1);

    // Pause with the counter at 2, then resume from the held count.
    wait_cycles(2);
    apply_press();
    check_output("pause_running", 32'(running), 32'd0);
    check_output("pause_led", 32'(led), 32'h0);
    check_output("pause_bcd", 32'(bcd), 32'h03);
    wait_cycles(3);
    check_output("pause_hold_bcd", 32'(bcd), 32'h03);
    check_output("pause_hold_phase", 32'(phase), 32'd0);
    apply_press();
    check_output("resume_running", 32'(running), 32'd1);
    check_output("resume_led", 32'(led), 32'hC);
    wait_cycles(2);
    check_output("resume_tick_bcd", 32'(bcd), 32'h02);

    // Press lands on the tick cycle: tick discarded, counter held at the limit.
    wait_cycles(3);
    apply_press();
    check_output("coinc_running", 32'(running), 32'd0);
    check_output("coinc_bcd", 32'(bcd), 32'h02);
    wait_cycles(2);
    apply_press();
    check_output("coinc_resume_bcd", 32'(bcd), 32'h02);
    wait_cycles(1);
    check_output("coinc_tick_bcd", 32'(bcd), 32'h01);

    // Power switch during SUN.
    wait_cycles(8);
    check_output("en_pre_phase", 32'(phase), 32'd1);
    check_output("en_pre_bcd", 32'(bcd), 32'h02);
    en = 1'b0;
    wait_cycles(1);
    check_output("en_off_running", 32'(running), 32'd0);
    check_output("en_off_phase", 32'(phase), 32'd0);
    check_output("en_off_bcd", 32'(bcd), 32'h03);
    check_output("en_off_led", 32'(led), 32'h0);
    en = 1'b1;
    wait_cycles(2);
    check_output("en_on_idle", 32'(running), 32'd0);

    // Demo rate from IDLE, then a mid-period switch into demo mode.
    demo = 1'b1;
    apply_press();
    check_output("demo_start_bcd", 32'(bcd), 32'h03);
    wait_cycles(1);
    check_output("demo_q1_bcd", 32'(bcd), 32'h03);
    wait_cycles(1);
    check_output("demo_q2_bcd", 32'(bcd), 32'h02);
    wait_cycles(2);
    check_output("demo_q4_bcd", 32'(bcd), 32'h01);
    demo = 1'b0;
    wait_cycles(2);
    check_output("demo_sw_pre_bcd", 32'(bcd), 32'h01);
    demo = 1'b1;
    wait_cycles(1);
    check_output("demo_sw_tick_bcd", 32'(bcd), 32'h00);
    demo = 1'b0;

    // Borrow across digits on the second instance.
    apply_press2();
    check_output("borrow_running", 32'(running2), 32'd1);
    wait_cycles(1);
    check_output("borrow_q1_bcd", 32'(bcd2), 32'h10);
    wait_cycles(1);
    check_output("borrow_q2_bcd", 32'(bcd2), 32'h09);
    wait_cycles(2);
    check_output("borrow_q4_bcd", 32'(bcd2), 32'h08);

    // Key held high across reset release must not start the sequencer.
    rst = 1'b0;
    key = 1'b1;
    wait_cycles(2);
    rst = 1'b1;
    wait_cycles(3);
    check_output("held_key_running", 32'(running), 32'd0);
    check_output("held_key_led", 32'(led), 32'h0);
    check_output("held_key_bcd", 32'(bcd), 32'h03);
    key = 1'b0;
    wait_cycles(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
